dmem_load_unit: RTL and testbench

//  Read-side companion to the data-memory store path. Accepts byte/half/word loads from the
//  MEM stage, issues word-aligned reads to the synchronous data BRAM, and extracts, aligns and

---
 rtl/dmem_pkg.sv | 11 +
 rtl/load_extract.sv | 16 +
 rtl/dmem_load_unit.sv | 85 ++++++++
 tb/tb_dmem_load_unit.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// dmem_pkg: size encodings shared with the store path, load FSM states and crossing test.
package dmem_pkg;
  localparam logic [1:0] SIZE_B = 2'b00;
  localparam logic [1:0] SIZE_H = 2'b01;
  localparam logic [1:0] SIZE_W = 2'b10;
  localparam logic [1:0] SIZE_X = 2'b11;
  typedef enum logic [1:0] {IDLE, RD0, RD1, RESP} state_t;
  function automatic logic crosses(input logic [1:0] size, input logic [1:0] off);
    return (size == SIZE_H && off == 2'd3) || (size == SIZE_W && off != 2'd0);
  endfunction
endpackage

// File: rtl/load_extract.sv
// load_extract: shift a two-word pair down by the byte offset, then mask and extend per size.
module load_extract
  import dmem_pkg::*;
(
  input  logic [63:0] pair,
  input  logic [1:0]  off,
  input  logic [1:0]  size,
  input  logic        uns,
  output logic [31:0] data
);
  logic [31:0] sh;
  assign sh = 32'(pair >> {off, 3'b000});
  always_comb
    data = size == SIZE_B ? {{24{~uns & sh[7]}}, sh[7:0]} :
           size == SIZE_H ? {{16{~uns & sh[15]}}, sh[15:0]} : sh;
endmodule

// File: rtl/dmem_load_unit.sv
// dmem_load_unit: byte/half/word loads from a synchronous BRAM, splitting word-crossing loads.
module dmem_load_unit
  import dmem_pkg::*;
#(
  parameter int ADDR_W   = 32,
  parameter bit SPLIT_EN = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  output logic              mem_re,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [31:0]       mem_rdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_data,
  output logic              rsp_err
);
  state_t state, next;
  logic [ADDR_W-3:0] wa, wa_next;
  logic [1:0] off, size;
  logic uns, acc, bad_in, cross_r;
  logic [31:0] word0, ext;
  assign req_ready = state == IDLE;
  assign rsp_valid = state == RESP;
  assign acc = req_valid && req_ready;
  assign bad_in = req_size == SIZE_X || (!SPLIT_EN && crosses(req_size, req_addr[1:0]));
  assign cross_r = crosses(size, off);
  assign wa_next = wa + (ADDR_W-2)'(1);
  load_extract u_extract (
    .pair (state == RD1 ? {mem_rdata, word0} : {32'h0, mem_rdata}),
    .off  (off),
    .size (size),
    .uns  (uns),
    .data (ext)
  );
  // reset gates the combinational IDLE strobe so no read escapes while rst is held low
  always_comb begin
    next = state;
    mem_re = 1'b0;
    mem_addr = '0;
    unique case (state)
      IDLE: begin
        next = acc ? (bad_in ? RESP : RD0) : IDLE;
        mem_re = rst && req_valid && !bad_in;
        mem_addr = mem_re ? {req_addr[ADDR_W-1:2], 2'b00} : '0;
      end
      RD0: begin
        next = cross_r ? RD1 : RESP;
        mem_re = cross_r;
        mem_addr = cross_r ? {wa_next, 2'b00} : '0;
      end
      RD1: next = RESP;
      RESP: next = rsp_ready ? IDLE : RESP;
    endcase
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      wa <= '0;
      off <= '0;
      size <= '0;
      uns <= 1'b0;
      word0 <= '0;
      rsp_data <= '0;
      rsp_err <= 1'b0;
    end else begin
      state <= next;
      if (acc) begin
        wa <= req_addr[ADDR_W-1:2];
        off <= req_addr[1:0];
        size <= req_size;
        uns <= req_unsigned;
        rsp_err <= bad_in;
        rsp_data <= '0;
      end
      if (state == RD0) word0 <= mem_rdata;
      if ((state == RD0 && !cross_r) || state == RD1) rsp_data <= ext;
    end
  end
endmodule

// File: tb/tb_dmem_load_unit.sv
// tb_dmem_load_unit: directed load vectors against a split-enabled and a split-disabled unit.
module tb_dmem_load_unit;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;
  logic va = 1'b0, vb = 1'b0, rdy = 1'b0, uns = 1'b0, sel = 1'b0;
  logic [31:0] addr = '0;
  logic [1:0] size = '0;
  logic ready_a, re_a, rv_a, err_a, ready_b, re_b, rv_b, err_b;
  logic [31:0] maddr_a, rdata_a, data_a, maddr_b, rdata_b, data_b;
  logic [31:0] mem [16];
  logic [31:0] q [$];
  int checks = 0, errors = 0;

  dmem_load_unit #(.ADDR_W(32), .SPLIT_EN(1'b1)) dut (
    .clk(clk), .rst(rst), .req_valid(va), .req_ready(ready_a), .req_addr(addr),
    .req_size(size), .req_unsigned(uns), .mem_re(re_a), .mem_addr(maddr_a),
    .mem_rdata(rdata_a), .rsp_valid(rv_a), .rsp_ready(rdy), .rsp_data(data_a), .rsp_err(err_a)
  );
  dmem_load_unit #(.ADDR_W(32), .SPLIT_EN(1'b0)) dut_ns (
    .clk(clk), .rst(rst), .req_valid(vb), .req_ready(ready_b), .req_addr(addr),
    .req_size(size), .req_unsigned(uns), .mem_re(re_b), .mem_addr(maddr_b),
    .mem_rdata(rdata_b), .rsp_valid(rv_b), .rsp_ready(rdy), .rsp_data(data_b), .rsp_err(err_b)
  );

  always @(posedge clk) begin
    if (re_a) rdata_a <= mem[maddr_a[5:2]];
    if (re_b) rdata_b <= mem[maddr_b[5:2]];
    if (sel ? re_b : re_a) q.push_back(sel ? maddr_b : maddr_a);
  end

  logic o_ready, o_rv, o_err;
  logic [31:0] o_data;
  assign o_ready = sel ? ready_b : ready_a;
  assign o_rv = sel ? rv_b : rv_a;
  assign o_err = sel ? err_b : err_a;
  assign o_data = sel ? data_b : data_a;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        b;
    logic [31:0] w4;
    logic [31:0] a;
    logic [1:0]  s;
    logic        u;
    logic [31:0] d;
    logic        e;
    int          lat;
    int          nre;
    logic [31:0] a0;
    logic [31:0] a1;
  } vec_t;

  task automatic run(input vec_t v, input int hold);
    int lat;
    @(negedge clk);
    mem[4] = v.w4;
    sel = v.b;
    q.delete();
    chk("req_ready_idle", 32'(o_ready), 32'd1);
    addr = v.a;
    size = v.s;
    uns = v.u;
    va = !v.b;
    vb = v.b;
    @(posedge clk);
    #1 va = 1'b0;
    vb = 1'b0;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!o_rv && lat < 10);
    chk("latency", 32'(lat), 32'(v.lat));
    chk("data", o_data, v.d);
    chk("err", 32'(o_err), 32'(v.e));
    chk("mem_re_count", 32'(q.size()), 32'(v.nre));
    if (v.nre > 0 && q.size() > 0) chk("mem_addr0", q[0], v.a0);
    if (v.nre > 1 && q.size() > 1) chk("mem_addr1", q[1], v.a1);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("hold_valid", 32'(o_rv), 32'd1);
      chk("hold_data", o_data, v.d);
      chk("hold_req_ready", 32'(o_ready), 32'd0);
    end
    @(negedge clk);
    rdy = 1'b1;
    @(posedge clk);
    #1 rdy = 1'b0;
  endtask

  localparam logic [31:0] WA = 32'h8899AABB;
  localparam logic [31:0] WB = 32'h44332211;
  vec_t vecs [15];

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = '0;
    mem[5] = 32'h88776655;
    mem[15] = 32'hDDCCBBAA;
    mem[0] = 32'h11223344;
    vecs[0]  = '{0, WA, 32'h13, 2'b00, 0, 32'hFFFFFF88, 0, 2, 1, 32'h10, 0};
    vecs[1]  = '{0, WA, 32'h13, 2'b00, 1, 32'h00000088, 0, 2, 1, 32'h10, 0};
    vecs[2]  = '{0, WA, 32'h12, 2'b01, 0, 32'hFFFF8899, 0, 2, 1, 32'h10, 0};
    vecs[3]  = '{0, WA, 32'h10, 2'b01, 1, 32'h0000AABB, 0, 2, 1, 32'h10, 0};
    vecs[4]  = '{0, WA, 32'h10, 2'b00, 0, 32'hFFFFFFBB, 0, 2, 1, 32'h10, 0};
    vecs[5]  = '{0, WA, 32'h12, 2'b01, 1, 32'h00008899, 0, 2, 1, 32'h10, 0};
    vecs[6]  = '{0, WB, 32'h11, 2'b10, 0, 32'h55443322, 0, 3, 2, 32'h10, 32'h14};
    vecs[7]  = '{0, WB, 32'h13, 2'b01, 0, 32'h00005544, 0, 3, 2, 32'h10, 32'h14};
    vecs[8]  = '{0, WB, 32'h11, 2'b00, 0, 32'h00000022, 0, 2, 1, 32'h10, 0};
    vecs[9]  = '{0, WB, 32'h12, 2'b01, 0, 32'h00004433, 0, 2, 1, 32'h10, 0};
    vecs[10] = '{0, WB, 32'hFFFFFFFE, 2'b10, 0, 32'h3344DDCC, 0, 3, 2, 32'hFFFFFFFC, 32'h0};
    vecs[11] = '{0, WB, 32'h10, 2'b11, 0, 32'h0, 1, 1, 0, 0, 0};
    vecs[12] = '{1, WB, 32'h11, 2'b10, 0, 32'h0, 1, 1, 0, 0, 0};
    vecs[13] = '{1, WB, 32'h13, 2'b01, 0, 32'h0, 1, 1, 0, 0, 0};
    vecs[14] = '{1, WB, 32'h10, 2'b10, 0, 32'h44332211, 0, 2, 1, 32'h10, 0};

    va = 1'b1;
    addr = 32'h13;
    #12;
    chk("rst_req_ready", 32'(ready_a), 32'd1);
    chk("rst_mem_re", 32'(re_a), 32'd0);
    chk("rst_mem_addr", maddr_a, 32'h0);
    chk("rst_rsp_valid", 32'(rv_a), 32'd0);
    chk("rst_rsp_data", data_a, 32'h0);
    chk("rst_rsp_err", 32'(err_a), 32'd0);
    va = 1'b0;
    @(negedge clk);
    rst = 1'b1;

    foreach (vecs[i]) run(vecs[i], 0);

    // backpressure: response held, then the next load goes straight in
    run(vecs[0], 5);
    run(vecs[3], 0);

    // reset while the second read of a split load is in flight
    @(negedge clk);
    sel = 1'b0;
    q.delete();
    addr = 32'hFFFFFFFE;
    size = 2'b10;
    uns = 1'b0;
    va = 1'b1;
    @(posedge clk);
    #1 va = 1'b0;
    @(posedge clk);
    #1;
    chk("rd1_reads_issued", 32'(q.size()), 32'd2);
    rst = 1'b0;
    #1;
    chk("abort_req_ready", 32'(ready_a), 32'd1);
    chk("abort_mem_re", 32'(re_a), 32'd0);
    chk("abort_mem_addr", maddr_a, 32'h0);
    chk("abort_rsp_valid", 32'(rv_a), 32'd0);
    chk("abort_rsp_err", 32'(err_a), 32'd0);
    chk("abort_rsp_data", data_a, 32'h0);
    @(negedge clk);
    @(negedge clk);
    chk("abort_no_rsp", 32'(rv_a), 32'd0);
    rst = 1'b1;
    run('{0, WB, 32'h10, 2'b10, 0, 32'h44332211, 0, 2, 1, 32'h10, 0}, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
